// File: rtl/acq_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : acq_seq_pkg                                                   |
// | Purpose  : shared state encoding and widths for the acquisition sequencer|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package acq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        ACQUIRE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int WIN_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/strobe_divider.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : strobe_divider                                                |
// | Purpose  : mod-SAMPLE_DIV counter; tick marks the wrap cycle             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module strobe_divider #(
    parameter int SAMPLE_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int                c_cnt_w = $clog2(SAMPLE_DIV + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(SAMPLE_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    // A clear in the same cycle suppresses the tick so abort never leaks a strobe.
    assign tick = en && !clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/acq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : acq_sequencer                                                 |
// | Purpose  : gain-settle hold, then windowed ADC sample strobes            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module acq_sequencer
    import acq_seq_pkg::*;
#(
    parameter int SAMPLE_DIV     = 100,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int WINDOW_SAMPLES = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic                              abort_i,
    input  logic                              cont_i,
    input  logic                              ds_ready_i,
    output logic                              settle_o,
    output logic                              busy_o,
    output logic                              sample_strobe_o,
    output logic [$clog2(WINDOW_SAMPLES)-1:0] sample_idx_o,
    output logic                              window_last_o,
    output logic                              done_o,
    output logic [WIN_CNT_W-1:0]              window_count_o,
    output logic                              overrun_o
);

    localparam int                   c_settle_w    = $clog2(SETTLE_CYCLES + 1);
    localparam int                   c_idx_w       = $clog2(WINDOW_SAMPLES);
    localparam logic [c_settle_w-1:0] c_settle_last = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last    = c_idx_w'(WINDOW_SAMPLES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic [c_idx_w-1:0]    r_idx;
    logic [WIN_CNT_W-1:0]  r_win_cnt;
    logic                  r_overrun;

    logic w_start;
    logic w_tick;
    logic w_strobe;
    logic w_miss;
    logic w_last;

    assign w_start  = (r_state == IDLE) && start_i && !abort_i;
    assign w_strobe = w_tick && ds_ready_i;
    assign w_miss   = w_tick && !ds_ready_i;
    assign w_last   = w_strobe && (r_idx == c_idx_last);

    strobe_divider #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state == ACQUIRE),
        .clr   (w_start || abort_i),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = SETTLE;
            SETTLE:  if (r_settle_cnt == c_settle_last) w_next_state = ACQUIRE;
            ACQUIRE: if (w_last && !cont_i) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (abort_i) begin
            w_next_state = IDLE;
        end
    end

    // Outputs are derived from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_o        <= 1'b0;
            busy_o          <= 1'b0;
            sample_strobe_o <= 1'b0;
            sample_idx_o    <= '0;
            window_last_o   <= 1'b0;
            done_o          <= 1'b0;
            r_settle_cnt    <= '0;
            r_idx           <= '0;
            r_win_cnt       <= '0;
            r_overrun       <= 1'b0;
        end else begin
            settle_o        <= (w_next_state == SETTLE);
            busy_o          <= (w_next_state != IDLE);
            sample_strobe_o <= w_strobe;
            window_last_o   <= w_last;
            done_o          <= (r_state == DONE) && !abort_i;
            if (w_strobe) begin
                sample_idx_o <= r_idx;
            end
            if (w_start) begin
                r_settle_cnt <= '0;
                r_idx        <= '0;
                r_win_cnt    <= '0;
                r_overrun    <= 1'b0;
            end else begin
                if (r_state == SETTLE) begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                end
                if (w_strobe) begin
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                end
                if (w_last && (r_win_cnt != '1)) begin
                    r_win_cnt <= r_win_cnt + 1'b1;
                end
                if (w_miss) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign window_count_o = r_win_cnt;
    assign overrun_o      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_acq_sequencer                                              |
// | Purpose  : directed scoreboard bench for acq_sequencer (DIV=4, SET=3, W=4)|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_acq_sequencer;

    localparam int SAMPLE_DIV     = 4;
    localparam int SETTLE_CYCLES  = 3;
    localparam int WINDOW_SAMPLES = 4;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        start_i    = 1'b0;
    logic        abort_i    = 1'b0;
    logic        cont_i     = 1'b0;
    logic        ds_ready_i = 1'b1;
    logic        settle_o;
    logic        busy_o;
    logic        sample_strobe_o;
    logic [1:0]  sample_idx_o;
    logic        window_last_o;
    logic        done_o;
    logic [15:0] window_count_o;
    logic        overrun_o;

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
    } exp_t;

    exp_t sb[$];
    exp_t e_cur;
    int   tests     = 0;
    int   fails     = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    acq_sequencer #(
        .SAMPLE_DIV     (SAMPLE_DIV),
        .SETTLE_CYCLES  (SETTLE_CYCLES),
        .WINDOW_SAMPLES (WINDOW_SAMPLES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .abort_i         (abort_i),
        .cont_i          (cont_i),
        .ds_ready_i      (ds_ready_i),
        .settle_o        (settle_o),
        .busy_o          (busy_o),
        .sample_strobe_o (sample_strobe_o),
        .sample_idx_o    (sample_idx_o),
        .window_last_o   (window_last_o),
        .done_o          (done_o),
        .window_count_o  (window_count_o),
        .overrun_o       (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(exp_t'{idx: 2'(i), last: (i == WINDOW_SAMPLES - 1)});
        end
    endtask

    // Leaves the bench 1 time unit after the edge that sampled start_i (edge 0).
    task automatic do_start();
        start_i = 1'b1;
        step(1);
        start_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sample_strobe_o) begin
                check("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e_cur = sb.pop_front();
                    check("strobe_idx", 32'(sample_idx_o), 32'(e_cur.idx));
                    check("strobe_last", 32'(window_last_o), 32'(e_cur.last));
                end
            end else begin
                check("last_unqualified", 32'(window_last_o), 32'd0);
            end
            if (done_o) begin
                done_seen++;
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check("rst_settle", 32'(settle_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_strobe", 32'(sample_strobe_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_count", 32'(window_count_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);

        // single-shot window, downstream always ready
        push_n(4);
        do_start();
        check("s1_settle_e0", 32'(settle_o), 32'd1);
        check("s1_busy_e0", 32'(busy_o), 32'd1);
        step(2);
        check("s1_settle_e2", 32'(settle_o), 32'd1);
        step(1);
        check("s1_settle_e3", 32'(settle_o), 32'd0);
        check("s1_busy_e3", 32'(busy_o), 32'd1);
        step(3);
        check("s1_strobe_e6", 32'(sample_strobe_o), 32'd0);
        step(1);
        check("s1_strobe_e7", 32'(sample_strobe_o), 32'd1);
        check("s1_idx_e7", 32'(sample_idx_o), 32'd0);
        step(12);
        check("s1_strobe_e19", 32'(sample_strobe_o), 32'd1);
        check("s1_last_e19", 32'(window_last_o), 32'd1);
        check("s1_count_e19", 32'(window_count_o), 32'd1);
        check("s1_done_e19", 32'(done_o), 32'd0);
        step(1);
        check("s1_done_e20", 32'(done_o), 32'd1);
        check("s1_busy_e20", 32'(busy_o), 32'd0);
        step(1);
        check("s1_done_e21", 32'(done_o), 32'd0);
        done_exp++;
        check("s1_done_pulses", 32'(done_seen), 32'(done_exp));
        check("s1_sb_empty", 32'(sb.size()), 32'd0);

        // continuous windows, cont_i wiggled mid-window, then abort
        push_n(4);
        push_n(3);
        cont_i = 1'b1;
        do_start();
        step(9);
        cont_i = 1'b0;
        step(2);
        cont_i = 1'b1;
        step(8);
        check("s2_count_e19", 32'(window_count_o), 32'd1);
        check("s2_last_e19", 32'(window_last_o), 32'd1);
        step(4);
        check("s2_strobe_e23", 32'(sample_strobe_o), 32'd1);
        check("s2_idx_e23", 32'(sample_idx_o), 32'd0);
        check("s2_busy_e23", 32'(busy_o), 32'd1);
        step(9);
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        check("s2_busy_abort", 32'(busy_o), 32'd0);
        check("s2_strobe_abort", 32'(sample_strobe_o), 32'd0);
        check("s2_count_abort", 32'(window_count_o), 32'd1);
        step(10);
        cont_i = 1'b0;
        check("s2_sb_empty", 32'(sb.size()), 32'd0);
        check("s2_done_pulses", 32'(done_seen), 32'(done_exp));

        // back-pressure on tick 2 (edge 11)
        push_n(4);
        do_start();
        check("s3_overrun_clr", 32'(overrun_o), 32'd0);
        step(10);
        ds_ready_i = 1'b0;
        step(1);
        ds_ready_i = 1'b1;
        check("s3_strobe_e11", 32'(sample_strobe_o), 32'd0);
        check("s3_overrun_e11", 32'(overrun_o), 32'd1);
        step(4);
        check("s3_idx_e15", 32'(sample_idx_o), 32'd1);
        step(8);
        check("s3_last_e23", 32'(window_last_o), 32'd1);
        check("s3_done_e23", 32'(done_o), 32'd0);
        step(1);
        check("s3_done_e24", 32'(done_o), 32'd1);
        check("s3_overrun_e24", 32'(overrun_o), 32'd1);
        step(1);
        done_exp++;

        // next start clears overrun; abort during settle
        do_start();
        check("s3_overrun_restart", 32'(overrun_o), 32'd0);
        check("s3_count_restart", 32'(window_count_o), 32'd0);
        step(1);
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        check("ab_settle", 32'(settle_o), 32'd0);
        check("ab_busy", 32'(busy_o), 32'd0);
        step(12);

        // start and abort together stay idle
        start_i = 1'b1;
        abort_i = 1'b1;
        step(1);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("sa_busy", 32'(busy_o), 32'd0);
        check("sa_settle", 32'(settle_o), 32'd0);
        step(10);
        check("sa_busy_late", 32'(busy_o), 32'd0);
        check("ab_sb_empty", 32'(sb.size()), 32'd0);
        check("ab_done_pulses", 32'(done_seen), 32'(done_exp));

        // asynchronous reset mid-acquisition
        push_n(4);
        push_n(2);
        cont_i = 1'b1;
        do_start();
        step(28);
        check("rs_count_pre", 32'(window_count_o), 32'd1);
        check("rs_idx_pre", 32'(sample_idx_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_busy", 32'(busy_o), 32'd0);
        check("rs_count", 32'(window_count_o), 32'd0);
        check("rs_idx", 32'(sample_idx_o), 32'd0);
        check("rs_settle", 32'(settle_o), 32'd0);
        check("rs_strobe", 32'(sample_strobe_o), 32'd0);
        check("rs_sb_empty", 32'(sb.size()), 32'd0);
        sb.delete();
        cont_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1);
        push_n(4);
        do_start();
        check("rs_settle_e0", 32'(settle_o), 32'd1);
        step(3);
        check("rs_settle_e3", 32'(settle_o), 32'd0);
        step(4);
        check("rs_strobe_e7", 32'(sample_strobe_o), 32'd1);
        step(13);
        check("rs_done_e20", 32'(done_o), 32'd1);
        check("rs_count_e20", 32'(window_count_o), 32'd1);
        step(1);
        done_exp++;

        // window counter saturation
        push_n(4);
        push_n(4);
        cont_i = 1'b1;
        do_start();
        step(9);
        force dut.r_win_cnt = 16'hFFFE;
        #1;
        release dut.r_win_cnt;
        check("sat_preload", 32'(window_count_o), 32'hFFFE);
        step(10);
        check("sat_e19", 32'(window_count_o), 32'hFFFF);
        step(16);
        check("sat_last_e35", 32'(window_last_o), 32'd1);
        check("sat_e35", 32'(window_count_o), 32'hFFFF);
        abort_i = 1'b1;
        step(1);
        abort_i = 1'b0;
        cont_i  = 1'b0;
        check("sat_busy_abort", 32'(busy_o), 32'd0);
        check("sat_count_kept", 32'(window_count_o), 32'hFFFF);
        step(5);
        check("sat_sb_empty", 32'(sb.size()), 32'd0);
        check("final_done_pulses", 32'(done_seen), 32'(done_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
